// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the three-lane memory controller
package mem_ctrl_pkg;

   localparam int NUM_LANES           = 3;
   localparam int DEFAULT_DATA_LEN    = 16;
   localparam int DEFAULT_ADDRESS_LEN = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_lane_fill.sv
// rtl/mem_lane_fill.sv - copies the lowest enabled lane's address/data onto every disabled lane
module mem_lane_fill
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_LEN    = DEFAULT_DATA_LEN,
   parameter int ADDRESS_LEN = DEFAULT_ADDRESS_LEN
) (
   input  logic [NUM_LANES-1:0]             mask_i,
   input  logic [NUM_LANES*ADDRESS_LEN-1:0] addr_i,
   input  logic [NUM_LANES*DATA_LEN-1:0]    wdata_i,
   output logic [NUM_LANES*ADDRESS_LEN-1:0] addr_o,
   output logic [NUM_LANES*DATA_LEN-1:0]    wdata_o
);

   logic [ADDRESS_LEN-1:0] fill_addr;
   logic [DATA_LEN-1:0]    fill_data;

   // Walk downwards so the lowest enabled lane is the last (winning) assignment.
   always_comb begin
      fill_addr = addr_i[(NUM_LANES-1)*ADDRESS_LEN +: ADDRESS_LEN];
      fill_data = wdata_i[(NUM_LANES-1)*DATA_LEN +: DATA_LEN];
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            fill_addr = addr_i[i*ADDRESS_LEN +: ADDRESS_LEN];
            fill_data = wdata_i[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   always_comb begin
      addr_o  = '0;
      wdata_o = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         addr_o[i*ADDRESS_LEN +: ADDRESS_LEN] = mask_i[i] ? addr_i[i*ADDRESS_LEN +: ADDRESS_LEN] : fill_addr;
         wdata_o[i*DATA_LEN +: DATA_LEN]      = mask_i[i] ? wdata_i[i*DATA_LEN +: DATA_LEN] : fill_data;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-command controller driving a 3-port RAM; optional MEM_CTRL_COLLISION_CHECK_EN adds collision_err
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_LEN    = DEFAULT_DATA_LEN,
   parameter int ADDRESS_LEN = DEFAULT_ADDRESS_LEN
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [NUM_LANES-1:0]             cmd_mask,
   input  logic [NUM_LANES*ADDRESS_LEN-1:0] cmd_addr,
   input  logic [NUM_LANES*DATA_LEN-1:0]    cmd_wdata,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [NUM_LANES*DATA_LEN-1:0]    rsp_data,
   output logic                             ram_read,
   output logic                             ram_write,
   output logic [NUM_LANES*ADDRESS_LEN-1:0] ram_address,
   output logic [NUM_LANES*DATA_LEN-1:0]    ram_data_in,
`ifdef MEM_CTRL_COLLISION_CHECK_EN
   output logic                             collision_err,
`endif
   input  logic [NUM_LANES*DATA_LEN-1:0]    ram_data_out
);

   localparam int AW = NUM_LANES * ADDRESS_LEN;
   localparam int DW = NUM_LANES * DATA_LEN;

   state_e               state_q, state_d;
   logic                 write_q;
   logic [NUM_LANES-1:0] mask_q;
   logic [AW-1:0]        addr_q, ram_addr_q, fill_addr;
   logic [DW-1:0]        wdata_q, ram_din_q, fill_wdata, rsp_data_q, rsp_data_d;
   logic                 handshake, issue_any;

   assign handshake = cmd_valid && (state_q == IDLE);
   assign issue_any = (state_q == ISSUE) && (|mask_q);

   mem_lane_fill #(
      .DATA_LEN    (DATA_LEN),
      .ADDRESS_LEN (ADDRESS_LEN)
   ) u_lane_fill (
      .mask_i  (mask_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .addr_o  (fill_addr),
      .wdata_o (fill_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid) state_d = ISSUE;
         ISSUE:   state_d = write_q ? IDLE : WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM buses show the filled command only while issuing, otherwise the last issued value.
   always_comb begin
      cmd_ready   = (state_q == IDLE);
      rsp_valid   = (state_q == RESP);
      ram_read    = issue_any && !write_q;
      ram_write   = issue_any && write_q;
      ram_address = issue_any ? fill_addr : ram_addr_q;
      ram_data_in = (issue_any && write_q) ? fill_wdata : ram_din_q;
      rsp_data    = rsp_data_q;
   end

   always_comb begin
      rsp_data_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mask_q[i]) rsp_data_d[i*DATA_LEN +: DATA_LEN] = ram_data_out[i*DATA_LEN +: DATA_LEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q    <= 1'b0;
         mask_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         if (handshake) begin
            write_q <= cmd_write;
            mask_q  <= cmd_mask;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
         end
         if (issue_any) begin
            ram_addr_q <= fill_addr;
            if (write_q) ram_din_q <= fill_wdata;
         end
         if (state_q == WAIT) rsp_data_q <= rsp_data_d;
      end
   end

`ifdef MEM_CTRL_COLLISION_CHECK_EN
   always_comb begin
      collision_err = 1'b0;
      if (state_q == ISSUE && write_q) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
               if (mask_q[i] && mask_q[j]
                   && addr_q[i*ADDRESS_LEN +: ADDRESS_LEN] == addr_q[j*ADDRESS_LEN +: ADDRESS_LEN]
                   && wdata_q[i*DATA_LEN +: DATA_LEN] != wdata_q[j*DATA_LEN +: DATA_LEN])
                  collision_err = 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a 3-port RAM model
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_mask;
   logic [23:0] cmd_addr;
   logic [47:0] cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [47:0] rsp_data;
   logic        ram_read, ram_write;
   logic [23:0] ram_address;
   logic [47:0] ram_data_in;
   logic [47:0] ram_data_out = '0;
`ifdef MEM_CTRL_COLLISION_CHECK_EN
   logic        collision_err;
`endif

   logic [15:0] mem [256];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.DATA_LEN(16), .ADDRESS_LEN(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_mask     (cmd_mask),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .ram_read     (ram_read),
      .ram_write    (ram_write),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
`ifdef MEM_CTRL_COLLISION_CHECK_EN
      .collision_err(collision_err),
`endif
      .ram_data_out (ram_data_out)
   );

   // 3-port RAM: read data appears the cycle after ram_read is sampled
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      for (int l = 0; l < 3; l++) begin
         if (ram_write) mem[ram_address[l*8 +: 8]] <= ram_data_in[l*16 +: 16];
         if (ram_read)  ram_data_out[l*16 +: 16] <= mem[ram_address[l*8 +: 8]];
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         total++;
         if (ram_read && ram_write) begin
            bad++;
            $display("FAIL strobe_exclusive read=%b write=%b expected not both", ram_read, ram_write);
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // returns at the falling edge inside the ISSUE cycle
   task automatic send_cmd(input logic w, input logic [2:0] m, input logic [23:0] a, input logic [47:0] d);
      @(negedge clk);
      cmd_write = w; cmd_mask = m; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++;
      if ({cmd_ready, rsp_valid, ram_read, ram_write} !== 4'b1000) begin
         bad++; $display("FAIL reset_ctrl actual=%b expected=1000", {cmd_ready, rsp_valid, ram_read, ram_write});
      end
      total++;
      if ({ram_address, ram_data_in, rsp_data} !== '0) begin
         bad++; $display("FAIL reset_buses addr=%h din=%h rsp=%h expected 0", ram_address, ram_data_in, rsp_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after actual=%b expected=1", cmd_ready); end
   endtask

   task automatic test_read;
      preload(8'd62, 16'd10); preload(8'd63, 16'd3); preload(8'd64, 16'd1);
      send_cmd(1'b0, 3'b111, {8'd64, 8'd63, 8'd62}, 48'h0);
      total++;
      if ({ram_read, ram_write, cmd_ready, rsp_valid} !== 4'b1000) begin
         bad++; $display("FAIL read_issue_ctrl actual=%b expected=1000", {ram_read, ram_write, cmd_ready, rsp_valid});
      end
      total++;
      if (ram_address !== {8'd64, 8'd63, 8'd62}) begin
         bad++; $display("FAIL read_issue_addr actual=%h expected=403f3e", ram_address);
      end
      @(negedge clk);
      total++;
      if ({rsp_valid, ram_read} !== 2'b00) begin bad++; $display("FAIL read_wait actual=%b expected=00", {rsp_valid, ram_read}); end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL read_latency rsp_valid=%b expected=1", rsp_valid); end
      total++;
      if (rsp_data !== {16'd1, 16'd3, 16'd10}) begin
         bad++; $display("FAIL read_data actual=%h expected=00010003000a", rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL read_done actual=%b expected=10", {cmd_ready, rsp_valid}); end
   endtask

   task automatic test_write_fill;
      preload(8'd7, 16'h1234);
      send_cmd(1'b1, 3'b101, {8'd125, 8'd7, 8'd124}, {16'd6, 16'd99, 16'd5});
      total++;
      if ({ram_write, ram_read, cmd_ready} !== 3'b100) begin
         bad++; $display("FAIL write_issue_ctrl actual=%b expected=100", {ram_write, ram_read, cmd_ready});
      end
      total++;
      if (ram_address !== {8'd125, 8'd124, 8'd124}) begin
         bad++; $display("FAIL write_fill_addr actual=%h expected=7d7c7c", ram_address);
      end
      total++;
      if (ram_data_in !== {16'd6, 16'd5, 16'd5}) begin
         bad++; $display("FAIL write_fill_data actual=%h expected=000600050005", ram_data_in);
      end
      @(negedge clk);
      total++;
      if ({cmd_ready, ram_write, rsp_valid} !== 3'b100) begin
         bad++; $display("FAIL write_ready_latency actual=%b expected=100", {cmd_ready, ram_write, rsp_valid});
      end
      total++;
      if (ram_address !== {8'd125, 8'd124, 8'd124}) begin
         bad++; $display("FAIL write_addr_hold actual=%h expected=7d7c7c", ram_address);
      end
      total++;
      if ({mem[124], mem[125], mem[7]} !== {16'd5, 16'd6, 16'h1234}) begin
         bad++; $display("FAIL write_mem actual=%h/%h/%h expected=0005/0006/1234", mem[124], mem[125], mem[7]);
      end
   endtask

   task automatic test_mask_zero;
      send_cmd(1'b0, 3'b000, {8'd64, 8'd63, 8'd62}, 48'h0);
      total++;
      if ({ram_read, ram_write} !== 2'b00) begin bad++; $display("FAIL mask0_read_strobe actual=%b expected=00", {ram_read, ram_write}); end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 48'h0) begin
         bad++; $display("FAIL mask0_read_rsp valid=%b data=%h expected valid=1 data=0", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      send_cmd(1'b1, 3'b000, {8'd62, 8'd62, 8'd62}, {3{16'hffff}});
      total++;
      if ({ram_read, ram_write, cmd_ready} !== 3'b000) begin
         bad++; $display("FAIL mask0_write_issue actual=%b expected=000", {ram_read, ram_write, cmd_ready});
      end
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || mem[62] !== 16'd10) begin
         bad++; $display("FAIL mask0_write_done ready=%b mem62=%h expected ready=1 mem62=000a", cmd_ready, mem[62]);
      end
   endtask

   task automatic test_stall;
      logic [47:0] exp_data;
      exp_data = {16'h0000, 16'hbbbb, 16'haaaa};
      preload(8'd20, 16'haaaa); preload(8'd21, 16'hbbbb); preload(8'd22, 16'hcccc);
      send_cmd(1'b0, 3'b011, {8'd22, 8'd21, 8'd20}, 48'h0);
      total++;
      if (ram_address !== {8'd20, 8'd21, 8'd20}) begin
         bad++; $display("FAIL stall_fill_addr actual=%h expected=141514", ram_address);
      end
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== exp_data) begin
            bad++; $display("FAIL stall_hold cycle=%0d valid=%b ready=%b data=%h expected 1/0/%h", c, rsp_valid, cmd_ready, rsp_data, exp_data);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL stall_release actual=%b expected=10", {cmd_ready, rsp_valid}); end
   endtask

   task automatic test_reset_abort;
      int seen;
      send_cmd(1'b0, 3'b111, {8'd22, 8'd21, 8'd20}, 48'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({cmd_ready, rsp_valid, ram_read, ram_write} !== 4'b1000) begin
         bad++; $display("FAIL abort_ctrl actual=%b expected=1000", {cmd_ready, rsp_valid, ram_read, ram_write});
      end
      total++;
      if ({ram_address, ram_data_in, rsp_data} !== '0) begin
         bad++; $display("FAIL abort_buses addr=%h din=%h rsp=%h expected 0", ram_address, ram_data_in, rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid || ram_read || ram_write) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_no_activity cycles_active=%0d expected=0", seen); end
   endtask

`ifdef MEM_CTRL_COLLISION_CHECK_EN
   task automatic test_collision;
      send_cmd(1'b1, 3'b111, {8'd131, 8'd130, 8'd130}, {16'd3, 16'd2, 16'd1});
      total++;
      if (collision_err !== 1'b1) begin bad++; $display("FAIL collision_pulse actual=%b expected=1", collision_err); end
      @(negedge clk);
      total++;
      if (collision_err !== 1'b0) begin bad++; $display("FAIL collision_clear actual=%b expected=0", collision_err); end
      send_cmd(1'b1, 3'b111, {8'd131, 8'd130, 8'd130}, {16'd3, 16'd1, 16'd1});
      total++;
      if (collision_err !== 1'b0) begin bad++; $display("FAIL collision_same_data actual=%b expected=0", collision_err); end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_mask = '0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      test_reset();
      test_read();
      test_write_fill();
      test_mask_zero();
      test_stall();
      test_reset_abort();
`ifdef MEM_CTRL_COLLISION_CHECK_EN
      test_collision();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DATA_LEN, default 16, data word width per lane.
REQ-002 Parameter ADDRESS_LEN, default 8, address width per lane; lane count fixed at 3.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  processor command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_mask  input  3  per-lane enable, bit i = lane i.
REQ-009 cmd_addr  input  3*ADDRESS_LEN  lane i at bits [i*ADDRESS_LEN +: ADDRESS_LEN].
REQ-010 cmd_wdata  input  3*DATA_LEN  lane i at bits [i*DATA_LEN +: DATA_LEN].
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer accepts read data.
REQ-013 rsp_data  output  3*DATA_LEN  read data, same lane packing as cmd_wdata.
REQ-014 ram_read, ram_write  output  1 each  strobes to the 3-port RAM.
REQ-015 ram_address  output  3*ADDRESS_LEN; ram_data_in  output  3*DATA_LEN.
REQ-016 ram_data_out  input  3*DATA_LEN  RAM read data, valid the cycle after ram_read is sampled.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; handshake is cmd_valid & cmd_ready on a rising edge.
REQ-019 On handshake, cmd_write, cmd_mask, cmd_addr and cmd_wdata SHALL be registered, and the FSM goes IDLE -> ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle and assert exactly one of ram_read/ram_write, driving only registered values.
REQ-021 Lane fill: each disabled lane SHALL take the address (and write data) of the lowest-index enabled lane, so all three RAM ports carry legal, non-conflicting traffic.
REQ-022 Mask 000: ISSUE SHALL assert neither strobe. A write returns to IDLE. A read proceeds to RESP with rsp_data = 0.
REQ-023 Write: ISSUE -> IDLE. Write-to-next-cmd_ready latency is 2 cycles after the handshake, and no response is produced.
REQ-024 Read: ISSUE -> WAIT. At the end of WAIT, ram_data_out SHALL be captured into rsp_data, with disabled lanes forced to 0. WAIT -> RESP.
REQ-025 In RESP, rsp_valid = 1 and rsp_data SHALL be held stable until rsp_ready; on rsp_valid & rsp_ready the FSM goes RESP -> IDLE.
REQ-026 Read latency: rsp_valid first rises 3 cycles after the handshake edge.
REQ-027 ram_read and ram_write SHALL never be asserted together, and SHALL be 0 outside ISSUE.
REQ-028 ram_address and ram_data_in SHALL hold their last driven value outside ISSUE.
REQ-029 cmd_valid de-assertion outside IDLE SHALL be ignored, and no command is buffered.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and zero all of the following: rsp_valid, rsp_data, ram_read, ram_write, ram_address, ram_data_in, and the command registers.
REQ-031 cmd_ready SHALL be 1 during and after reset.
REQ-032 Reset mid-operation SHALL abort it: no strobe is issued after rst_n falls, and a pending response is discarded.

Configuration
REQ-033 Macro MEM_CTRL_COLLISION_CHECK_EN: when defined, output port collision_err (1 bit) SHALL exist.
REQ-034 collision_err SHALL pulse high for the ISSUE cycle of a write in which two enabled lanes share an address but carry differing data. It is reset to 0.
REQ-035 Without MEM_CTRL_COLLISION_CHECK_EN, the port and its logic SHALL be absent and all other behaviour is unchanged.

Structure
REQ-036 Package mem_ctrl_pkg SHALL hold the FSM state typedef, the lane-count constant (3), and the default DATA_LEN/ADDRESS_LEN constants.
REQ-037 Lane-fill logic (REQ-021) SHALL be the sub-module mem_lane_fill, purely combinational, instantiated once in mem_ctrl.

Verification
REQ-038 Read, mask 111, addr {62,63,64}, RAM preloaded {10,3,1} -> rsp_valid 3 cycles after handshake, rsp_data lanes {10,3,1}.
REQ-039 Write, mask 101, addr {lane0=124, lane1=7, lane2=125}, wdata {5,99,6} -> RAM ports carry {124,124,125} with data {5,5,6}; mem[124]=5, mem[125]=6, mem[7] unchanged.
REQ-040 Read with rsp_ready held low 10 cycles -> rsp_data stable, cmd_ready 0 throughout. rsp_ready=1 -> IDLE next cycle.
REQ-041 rst_n pulsed low during WAIT -> rsp_valid never asserts, all outputs 0, cmd_ready 1 immediately.
REQ-042 Mask 000 read -> no ram strobe, rsp_data = 0. Mask 000 write -> no strobe, cmd_ready back after 2 cycles.
REQ-043 With MEM_CTRL_COLLISION_CHECK_EN: write mask 111, addr {130,130,131}, data {1,2,3} -> collision_err pulses 1 cycle. Same addresses with data {1,1,3} -> no pulse.
